latch_bank_arbiter: RTL and testbench

- Shares a single D-latch write port (d/e pair driving the team's D_flip_flop latch bank) between N_REQ requesters.
- Round-robin arbitration; each granted write is sequenced as setup -> enable pulse -> hold, so latch data is never changing while enable is high.
- Sits between requester logic and the latch bank; the only block allowed to drive the latch e input.

---
 rtl/latch_ctrl_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/latch_bank_arbiter.sv | 172 +++++++++++++++++
 tb/tb_latch_bank_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/latch_ctrl_pkg.sv
// Shared definitions for the latch bank write-port controller: FSM state
// encoding and the fixed lengths of the setup and hold phases.
package latch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam int SETUP_CYCLES = 1;
  localparam int HOLD_CYCLES  = 1;

  // Largest of three phase lengths, used to size the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request bit at or above the
// pointer, wrapping around. Produces a one-hot grant, its index and a valid.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] idx_o,
  output logic                     valid_o
);

  localparam int IDX_W = $clog2(N_REQ);

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    int unsigned k;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise the tool infers a latch.
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    k       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      k = (int'(ptr_i) + i) % N_REQ;
      if (!valid_o && req_i[k]) begin
        valid_o  = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/latch_bank_arbiter.sv
// Owns the single d/e write port of the latch bank and shares it between
// N_REQ requesters in round-robin order. Each write runs SETUP -> ENABLE ->
// HOLD so latch data is stable whenever the enable is high.
// Optional: define LATCH_READBACK_EN to add latch_q_i readback and a sticky
// err_o flag raised when the latch contents disagree with the written data.
module latch_bank_arbiter
  import latch_ctrl_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int EN_CYCLES = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*DATA_W-1:0]   data_i,
  output logic [N_REQ-1:0]          ack_o,
  output logic [DATA_W-1:0]         latch_d_o,
  output logic                      latch_e_o,
  output logic                      busy_o,
  output logic [$clog2(N_REQ)-1:0]  grant_idx_o
`ifdef LATCH_READBACK_EN
  ,
  input  logic [DATA_W-1:0]         latch_q_i,
  output logic                      err_o
`endif
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int PH_MAX = max3(SETUP_CYCLES, EN_CYCLES, HOLD_CYCLES);
  localparam int CNT_W  = $clog2(PH_MAX + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   gnt_oh_q, gnt_oh_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               e_q, e_d;
  logic [N_REQ-1:0]   ack_q, ack_d;

  logic [N_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // State register and phase counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: each phase lasts until its down-counter reaches zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = SETUP;
          cnt_d   = CNT_W'(SETUP_CYCLES - 1);
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = ENABLE;
          cnt_d   = CNT_W'(EN_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ENABLE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next values: enable and ack are derived from the next state so
  // they leave flops cleanly; grant, data and pointer load on their events.
  always_comb begin
    e_d      = (state_d == ENABLE);
    ack_d    = (state_d == HOLD && state_q != HOLD) ? gnt_oh_q : '0;
    grant_d  = grant_q;
    gnt_oh_d = gnt_oh_q;
    data_d   = data_q;
    ptr_d    = ptr_q;
    if (state_q == IDLE && arb_valid) begin
      grant_d  = arb_idx;
      gnt_oh_d = arb_gnt;
      data_d   = data_i[arb_idx*DATA_W +: DATA_W];
    end
    if (state_q == HOLD && state_d == IDLE) begin
      ptr_d = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
    end
  end

  // Output, data and round-robin pointer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      e_q      <= 1'b0;
      ack_q    <= '0;
      grant_q  <= '0;
      gnt_oh_q <= '0;
      data_q   <= '0;
      ptr_q    <= '0;
    end else begin
      e_q      <= e_d;
      ack_q    <= ack_d;
      grant_q  <= grant_d;
      gnt_oh_q <= gnt_oh_d;
      data_q   <= data_d;
      ptr_q    <= ptr_d;
    end
  end

  assign latch_e_o   = e_q;
  assign ack_o       = ack_q;
  assign latch_d_o   = data_q;
  assign grant_idx_o = grant_q;
  assign busy_o      = (state_q != IDLE);

`ifdef LATCH_READBACK_EN
  logic err_q, err_d;

  // Sticky readback error: compare the latch contents during HOLD.
  always_comb begin
    err_d = err_q;
    if (state_q == HOLD && latch_q_i != data_q) begin
      err_d = 1'b1;
    end
  end

  // Error flag register, cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`endif

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Self-checking bench for latch_bank_arbiter. A transaction-level model keeps
// the grant, its start edge and the round-robin pointer; expected outputs are
// derived from the elapsed edges since grant.
module tb_latch_bank_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int EN = 2;
  localparam int IW = $clog2(N);

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [N-1:0]   req_i;
  logic [N*W-1:0] data_i;
  logic [N-1:0]   ack_o;
  logic [W-1:0]   latch_d_o;
  logic           latch_e_o;
  logic           busy_o;
  logic [IW-1:0]  grant_idx_o;
`ifdef LATCH_READBACK_EN
  logic [W-1:0]   latch_q_i;
  logic           err_o;
  bit             rb_force;
  logic [W-1:0]   rb_val;
  assign latch_q_i = rb_force ? rb_val : latch_d_o;
`endif

  latch_bank_arbiter #(.N_REQ(N), .DATA_W(W), .EN_CYCLES(EN)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .data_i      (data_i),
    .ack_o       (ack_o),
    .latch_d_o   (latch_d_o),
    .latch_e_o   (latch_e_o),
    .busy_o      (busy_o),
    .grant_idx_o (grant_idx_o)
`ifdef LATCH_READBACK_EN
    ,
    .latch_q_i   (latch_q_i),
    .err_o       (err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Model state
  int           edge_n = 0;
  bit           m_busy;
  int           m_start, m_grant, m_ptr;
  logic [W-1:0] m_data;
  bit           m_err;

  logic [N-1:0] rearm;
  int           ack_log[$];

  task automatic model_reset();
    m_busy = 0; m_start = 0; m_grant = 0; m_ptr = 0; m_data = '0; m_err = 0;
  endtask

  // One clock: advance the model on the edge, then compare all outputs.
  task automatic step();
    logic [N-1:0]   r;
    logic [N*W-1:0] ds;
    logic [W-1:0]   prev_d;
    logic [N-1:0]   exp_ack;
    logic           exp_e;
    int             p;
`ifdef LATCH_READBACK_EN
    logic [W-1:0]   qs;
    qs = latch_q_i;
`endif
    r = req_i; ds = data_i; prev_d = latch_d_o;
    @(posedge clk_i);
    edge_n++;
    if (m_busy && (edge_n - m_start) == EN + 2) begin
      m_busy = 0;
      m_ptr  = (m_grant + 1) % N;
`ifdef LATCH_READBACK_EN
      if (qs !== m_data) m_err = 1;
`endif
    end else if (!m_busy && r != '0) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (r[k]) begin
          m_grant = k; m_data = ds[k*W +: W]; m_busy = 1; m_start = edge_n;
          break;
        end
      end
    end
    #1;
    p       = edge_n - m_start;
    exp_e   = m_busy && p >= 1 && p <= EN;
    exp_ack = '0;
    if (m_busy && p == EN + 1) exp_ack[m_grant] = 1'b1;
    total += 6;
    if (latch_e_o !== exp_e) begin
      bad++; $display("FAIL latch_e edge=%0d got=%b want=%b", edge_n, latch_e_o, exp_e);
    end
    if (ack_o !== exp_ack) begin
      bad++; $display("FAIL ack edge=%0d got=%b want=%b", edge_n, ack_o, exp_ack);
    end
    if (busy_o !== m_busy) begin
      bad++; $display("FAIL busy edge=%0d got=%b want=%b", edge_n, busy_o, m_busy);
    end
    if (latch_d_o !== m_data) begin
      bad++; $display("FAIL latch_d edge=%0d got=%h want=%h", edge_n, latch_d_o, m_data);
    end
    if (grant_idx_o !== IW'(m_grant)) begin
      bad++; $display("FAIL grant_idx edge=%0d got=%0d want=%0d", edge_n, grant_idx_o, m_grant);
    end
    if (latch_e_o === 1'b1 && latch_d_o !== prev_d) begin
      bad++; $display("FAIL d_while_e edge=%0d got=%h want=%h", edge_n, latch_d_o, prev_d);
    end
`ifdef LATCH_READBACK_EN
    total++;
    if (err_o !== m_err) begin
      bad++; $display("FAIL err edge=%0d got=%b want=%b", edge_n, err_o, m_err);
    end
`endif
    for (int k = 0; k < N; k++) begin
      if (ack_o[k] === 1'b1) begin
        ack_log.push_back(k);
        req_i[k] = 1'b0;
      end
    end
    req_i = req_i | rearm;
  endtask

  // Step until the ack log holds n entries, reporting an expired budget.
  task automatic run_acks(input int n, input int budget, input string name);
    int c = 0;
    while (ack_log.size() < n && c < budget) begin
      step(); c++;
    end
    total++;
    if (ack_log.size() < n) begin
      bad++; $display("FAIL %s_timeout got=%0d acks want=%0d", name, ack_log.size(), n);
    end
  endtask

  task automatic reset_dut();
    rst_i = 1'b1; req_i = '0; data_i = '0; rearm = '0;
    ack_log.delete(); model_reset();
`ifdef LATCH_READBACK_EN
    rb_force = 0; rb_val = '0;
`endif
    @(posedge clk_i); @(posedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; req_i = '0; data_i = '0; rearm = '0;
`ifdef LATCH_READBACK_EN
    rb_force = 0; rb_val = '0;
`endif
    #3 rst_i = 1'b1;
    #1;
    total += 5;
    if (latch_e_o !== 1'b0) begin bad++; $display("FAIL rst_e got=%b want=0", latch_e_o); end
    if (ack_o !== '0) begin bad++; $display("FAIL rst_ack got=%b want=0", ack_o); end
    if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy_o); end
    if (latch_d_o !== '0) begin bad++; $display("FAIL rst_d got=%h want=0", latch_d_o); end
    if (grant_idx_o !== '0) begin bad++; $display("FAIL rst_grant got=%0d want=0", grant_idx_o); end
    reset_dut();
    step(); step();
  endtask

  task automatic test_single_write();
    int n = 1, e_cnt = 0;
    reset_dut();
    data_i[0 +: W] = 8'hA5;
    req_i = 4'b0001;
    step();
    total++;
    if (latch_d_o !== 8'hA5 || latch_e_o !== 1'b0) begin
      bad++; $display("FAIL setup_phase got d=%h e=%b want d=a5 e=0", latch_d_o, latch_e_o);
    end
    while (ack_o === '0 && n < 20) begin
      step(); n++;
      if (latch_e_o === 1'b1) e_cnt++;
    end
    total += 2;
    if (n != EN + 2) begin bad++; $display("FAIL ack_latency got=%0d want=%0d", n, EN + 2); end
    if (e_cnt != EN) begin bad++; $display("FAIL e_width got=%0d want=%0d", e_cnt, EN); end
    step(); step();
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL busy_after got=%b want=0", busy_o); end
  endtask

  task automatic test_all_requests();
    reset_dut();
    data_i = {$urandom, $urandom} & '1;
    req_i = 4'b1111;
    run_acks(4, 80, "all_req");
    for (int i = 0; i < 4 && i < ack_log.size(); i++) begin
      total++;
      if (ack_log[i] != i) begin
        bad++; $display("FAIL rr_order slot=%0d got=%0d want=%0d", i, ack_log[i], i);
      end
    end
    step(); step();
  endtask

  task automatic test_no_starvation();
    int pos = -1;
    reset_dut();
    data_i = {$urandom, $urandom} & '1;
    req_i = 4'b0010; rearm = 4'b0010;
    step(); step();
    req_i[3] = 1'b1;
    for (int c = 0; c < 60 && pos < 0; c++) begin
      step();
      for (int i = 0; i < ack_log.size(); i++) if (ack_log[i] == 3 && pos < 0) pos = i;
    end
    total++;
    if (pos < 0 || pos > 1) begin
      bad++; $display("FAIL starvation got=%0d want<=1", pos);
    end
    rearm = '0; req_i = '0;
    for (int c = 0; c < 10; c++) step();
  endtask

  task automatic test_data_change();
    logic [W-1:0] orig;
    int c = 0;
    reset_dut();
    orig = W'($urandom);
    data_i[2*W +: W] = orig;
    req_i = 4'b0100;
    while (latch_e_o !== 1'b1 && c < 10) begin step(); c++; end
    data_i[2*W +: W] = ~orig;
    step();
    total++;
    if (latch_d_o !== orig) begin
      bad++; $display("FAIL data_change got=%h want=%h", latch_d_o, orig);
    end
    run_acks(1, 20, "data_change");
    step(); step();
  endtask

  task automatic test_reset_mid();
    int c = 0;
    reset_dut();
    data_i = {$urandom, $urandom} & '1;
    req_i = 4'b0010;
    run_acks(1, 20, "pre_reset");
    step();
    req_i = 4'b0100;
    while (latch_e_o !== 1'b1 && c < 10) begin step(); c++; end
    #2 rst_i = 1'b1;
    #1;
    total += 3;
    if (latch_e_o !== 1'b0) begin bad++; $display("FAIL mid_rst_e got=%b want=0", latch_e_o); end
    if (ack_o !== '0) begin bad++; $display("FAIL mid_rst_ack got=%b want=0", ack_o); end
    if (busy_o !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b want=0", busy_o); end
    model_reset(); ack_log.delete();
    req_i = 4'b1111;
    @(posedge clk_i); #1;
    total++;
    if (ack_o !== '0) begin bad++; $display("FAIL rst_held_ack got=%b want=0", ack_o); end
    @(negedge clk_i) rst_i = 1'b0;
    run_acks(1, 20, "post_reset");
    total++;
    if (ack_log.size() > 0 && ack_log[0] != 0) begin
      bad++; $display("FAIL post_reset_grant got=%0d want=0", ack_log[0]);
    end
    req_i = '0;
    for (int c2 = 0; c2 < 8; c2++) step();
  endtask

  task automatic test_random();
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!req_i[k] && $urandom_range(0, 3) == 0) begin
          data_i[k*W +: W] = W'($urandom);
          req_i[k] = 1'b1;
        end else if (!req_i[k]) begin
          data_i[k*W +: W] = W'($urandom);
        end
      end
      step();
    end
    req_i = '0;
    for (int c = 0; c < 10; c++) step();
  endtask

`ifdef LATCH_READBACK_EN
  task automatic test_readback();
    reset_dut();
    rb_force = 1; rb_val = 8'h00;
    data_i[0 +: W] = 8'h3C; req_i = 4'b0001;
    run_acks(1, 20, "rb_bad");
    step(); step();
    total++;
    if (err_o !== 1'b1) begin bad++; $display("FAIL rb_err_set got=%b want=1", err_o); end
    rb_force = 0;
    data_i[W +: W] = 8'h3C; req_i = 4'b0010;
    run_acks(2, 20, "rb_sticky");
    step(); step();
    total++;
    if (err_o !== 1'b1) begin bad++; $display("FAIL rb_err_sticky got=%b want=1", err_o); end
    reset_dut();
    data_i[0 +: W] = 8'h3C; req_i = 4'b0001;
    run_acks(1, 20, "rb_good");
    step(); step();
    total++;
    if (err_o !== 1'b0) begin bad++; $display("FAIL rb_err_clean got=%b want=0", err_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_all_requests();
    test_no_starvation();
    test_data_change();
    test_reset_mid();
    test_random();
`ifdef LATCH_READBACK_EN
    test_readback();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
